// File: rtl/peak_capture_register.sv
// rtl/peak_capture_register.sv - sweep-peak holding stage for the solar-tracker ADC path
// Holds each accepted sample for the external comparator and keeps the running maximum and its position.
module peak_capture_register #(
   parameter int POS_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [11:0]      adc_data,
   input  logic             sample_valid,
   input  logic             sample_last,
   input  logic [POS_W-1:0] pos,
   input  logic             gt,
   output logic [11:0]      cmp_pv,
   output logic [11:0]      lv,
   output logic [POS_W-1:0] max_pos,
   output logic             busy,
   output logic             done,
   output logic [7:0]       miss_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WAIT,
      SETTLE,
      DECIDE,
      FINISH
   } state_t;

   state_t           state;
   logic             first;
   logic [POS_W-1:0] s_pos;
   logic             s_last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cmp_pv   <= '0;
         lv       <= '0;
         max_pos  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         miss_cnt <= '0;
         first    <= 1'b0;
         s_pos    <= '0;
         s_last   <= 1'b0;
      end else begin
         done <= 1'b0;
         // Any sample offered while busy outside WAIT is dropped and counted.
         if (busy && state != WAIT && sample_valid && miss_cnt != 8'hff)
            miss_cnt <= miss_cnt + 8'd1;
         case (state)
            IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  state <= CLEAR;
               end
            end
            CLEAR: begin
               lv       <= '0;
               max_pos  <= '0;
               miss_cnt <= {7'd0, sample_valid};
               first    <= 1'b1;
               state    <= WAIT;
            end
            WAIT: begin
               if (sample_valid) begin
                  cmp_pv <= adc_data;
                  s_pos  <= pos;
                  s_last <= sample_last;
                  state  <= SETTLE;
               end
            end
            SETTLE: state <= DECIDE;
            DECIDE: begin
               // First sample of a sweep is taken unconditionally.
               if (gt || first) begin
                  lv      <= cmp_pv;
                  max_pos <= s_pos;
               end
               first <= 1'b0;
               if (s_last) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  state <= WAIT;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/peak_capture_register.md
# peak_capture_register

Sweep-peak holding stage that sits directly downstream of the voltage comparator in the solar-tracker ADC path. It latches each ADC sample and the servo position it was taken at, presents the held sample and the running maximum to the comparator, and consumes the registered greater flag to decide whether to overwrite the maximum. At sweep end it reports the peak value and the position where it occurred, which the tracker uses to park the panel.

## Interface
- POS_W, 8, width of servo position word
- CLK  in  1  system clock, all logic on rising edge
- RSTN  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse, begins a sweep (ignored while BUSY)
- ADC_DATA  in  12  ADC conversion result
- SAMPLE_VALID  in  1  ADC_DATA/POS/SAMPLE_LAST valid this cycle
- SAMPLE_LAST  in  1  qualifies final sample of the sweep
- POS  in  POS_W  servo position at which ADC_DATA was taken
- GT  in  1  registered greater flag from comparator (held sample > LV, upper 6 bits only)
- CMP_PV  out  12  held sample, drives comparator pending-value input
- LV  out  12  running maximum, drives comparator last-value input
- MAX_POS  out  POS_W  position of running/final maximum
- BUSY  out  1  high from START acceptance until DONE
- DONE  out  1  one-cycle pulse when sweep result is final
- MISS_CNT  out  8  samples dropped during the sweep, saturating

## Operation
- States: IDLE, CLEAR, WAIT, SETTLE, DECIDE, FINISH.
- IDLE: BUSY=0. START=1 -> CLEAR. SAMPLE_VALID ignored, not counted.
- CLEAR (1 cycle): LV<=0, MAX_POS<=0, MISS_CNT<=0, FIRST<=1 -> WAIT.
- WAIT: SAMPLE_VALID=1 -> CMP_PV<=ADC_DATA, S_POS<=POS, S_LAST<=SAMPLE_LAST -> SETTLE.
- SETTLE (1 cycle): comparator registers GT from CMP_PV/LV on this edge -> DECIDE.
- DECIDE: if GT=1 or FIRST=1 -> LV<=CMP_PV, MAX_POS<=S_POS; FIRST<=0. Then S_LAST=1 -> FINISH, else -> WAIT.
- FINISH (1 cycle): DONE=1 -> IDLE. LV/MAX_POS hold until next START's CLEAR.
- First sample of a sweep always captured regardless of GT (covers all-zero-upper-bit sweeps).
- Equal upper 6 bits: GT=0, earlier position retained (first occurrence wins). Low 6 bits never influence capture.
- SAMPLE_VALID=1 while BUSY and state not WAIT (CLEAR, SETTLE, DECIDE, FINISH): sample dropped, MISS_CNT+1, saturating at 255. A dropped SAMPLE_LAST is lost; sweep continues until an accepted SAMPLE_LAST.
- START while BUSY: ignored, no effect on state or counters.
- Arithmetic: no arithmetic on data; MISS_CNT 8-bit saturating increment only.

## Timing
- Reset (RSTN=0, asynchronous): state IDLE, CMP_PV=0, LV=0, MAX_POS=0, BUSY=0, DONE=0, MISS_CNT=0, FIRST=0; release synchronous to next CLK edge.
- START at edge k -> CLEAR after k; BUSY=1 from after edge k.
- Sample accepted at edge n (WAIT): GT valid at edge n+1, LV/MAX_POS update at edge n+2, next sample acceptable at edge n+3. Minimum sample spacing 3 cycles.
- Last sample accepted at edge n: FINISH after n+2, DONE=1 for cycle n+2..n+3, BUSY falls after edge n+3; DONE and BUSY both high in FINISH.
- CMP_PV and LV only change on acceptance/capture edges, so GT sampled in DECIDE always reflects current LV.
- RSTN asserted mid-sweep: immediate return to IDLE, all outputs to reset values, no DONE.

## Test plan
- Reset: assert RSTN=0 mid-SETTLE -> all outputs 0, state IDLE, no DONE after release.
- Basic sweep: samples 0x100@pos3, 0x800@pos7, 0x400@pos9(last), 3-cycle spacing -> DONE with LV=0x800, MAX_POS=7, MISS_CNT=0.
- Low-bit masking/tie: 0x840@pos2 then 0x87F@pos5(last) -> LV=0x840, MAX_POS=2 (upper bits equal, first wins).
- First-sample capture: single sample 0x03F@pos12 with SAMPLE_LAST -> LV=0x03F, MAX_POS=12, DONE 2 cycles after acceptance.
- Dropped samples: SAMPLE_VALID held high every cycle for 9 cycles, SAMPLE_LAST on cycle 9 -> 3 accepted, MISS_CNT=6, sweep ends only when SAMPLE_LAST is accepted (DONE absent if last dropped).
- START while BUSY and saturation: pulse START mid-sweep -> no restart; 300 dropped samples -> MISS_CNT=255.
